// File: rtl/render_sched_pkg.sv
// Shared types for the render frame scheduler: FSM state encoding and counter width.
package render_sched_pkg;

    typedef enum logic [2:0] {
        S_Idle     = 3'd0,
        S_Issue    = 3'd1,
        S_WaitBusy = 3'd2,
        S_Running  = 3'd3,
        S_Cooldown = 3'd4
    } sched_state_t;

    localparam int SAT_COUNT_WIDTH = 16;

endpackage

// File: rtl/render_sched_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones once reached.
module render_sched_sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             increment,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (increment && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/render_frame_scheduler.sv
// Frame start scheduler: merges host/vblank requests into one pending slot, issues start pulses
// with a post-frame gap. Optional watchdog abort is compiled in with RENDER_SCHED_WATCHDOG_EN.
module render_frame_scheduler
    import render_sched_pkg::*;
#(
    parameter int          MIN_GAP_CYCLES  = 16,
    parameter logic [31:0] WATCHDOG_CYCLES = 32'd50_000_000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       hostStart_tick,
    input  logic                       autoMode,
    input  logic                       vblank_tick,
    input  logic                       flowBusy,
    input  logic                       flowDone_tick,
    output logic                       startRequest_tick,
    output logic                       flowAbort_tick,
    output logic                       pending,
    output logic                       active,
    output logic [31:0]                framesIssued,
    output logic [SAT_COUNT_WIDTH-1:0] framesDropped,
    output logic [SAT_COUNT_WIDTH-1:0] timeoutCount,
    output logic [31:0]                lastLatency,
    output sched_state_t               debugState
);

    localparam logic [31:0]  GAP_LAST   = (MIN_GAP_CYCLES > 0) ? 32'(MIN_GAP_CYCLES - 1) : 32'd0;
    localparam sched_state_t DONE_STATE = (MIN_GAP_CYCLES > 0) ? S_Cooldown : S_Idle;

    sched_state_t state, stateNext;
    logic         requestEvent, consume, dropEvent, inFrame, frameDone, timeout;
    logic [31:0]  latencyCount, gapCount;

    // An event arriving while the slot is being consumed simply re-latches it.
    assign requestEvent = hostStart_tick | (autoMode & vblank_tick);
    assign consume      = (state == S_Idle) && pending;
    assign dropEvent    = requestEvent && pending && !consume;
    assign inFrame      = (state == S_WaitBusy) || (state == S_Running);
    assign frameDone    = inFrame && flowDone_tick;

`ifdef RENDER_SCHED_WATCHDOG_EN
    logic [31:0] watchdogCount;

    // Done in the same cycle as the timeout takes priority.
    assign timeout = inFrame && !flowDone_tick && (watchdogCount == WATCHDOG_CYCLES);

    always_ff @(posedge clock) begin
        if (reset || (state == S_Issue)) begin
            watchdogCount <= '0;
        end else if (inFrame) begin
            watchdogCount <= watchdogCount + 32'd1;
        end
    end

    render_sched_sat_counter #(.WIDTH(SAT_COUNT_WIDTH)) timeoutCounter (
        .clock     (clock),
        .clear     (reset),
        .increment (timeout),
        .count     (timeoutCount)
    );

    assign flowAbort_tick = timeout;
`else
    logic unusedWatchdog;
    assign unusedWatchdog = ^WATCHDOG_CYCLES;
    assign timeout        = 1'b0;
    assign flowAbort_tick = 1'b0;
    assign timeoutCount   = '0;
`endif

    always_comb begin
        stateNext = state;
        case (state)
            S_Idle:     if (pending) stateNext = S_Issue;
            S_Issue:    stateNext = S_WaitBusy;
            S_WaitBusy: begin
                if (flowDone_tick)  stateNext = DONE_STATE;
                else if (timeout)   stateNext = S_Cooldown;
                else if (flowBusy)  stateNext = S_Running;
            end
            S_Running: begin
                if (flowDone_tick)  stateNext = DONE_STATE;
                else if (timeout)   stateNext = S_Cooldown;
            end
            S_Cooldown: if (gapCount == GAP_LAST) stateNext = S_Idle;
            default:    stateNext = S_Idle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= S_Idle;
            pending      <= 1'b0;
            framesIssued <= '0;
            latencyCount <= '0;
            gapCount     <= '0;
            lastLatency  <= '0;
        end else begin
            state   <= stateNext;
            pending <= requestEvent | (pending & ~consume);
            if (state == S_Issue) begin
                framesIssued <= framesIssued + 32'd1;
                latencyCount <= '0;
            end else if (inFrame) begin
                latencyCount <= latencyCount + 32'd1;
            end
            if (frameDone) lastLatency <= latencyCount + 32'd1;
            gapCount <= (state == S_Cooldown) ? gapCount + 32'd1 : 32'd0;
        end
    end

    render_sched_sat_counter #(.WIDTH(SAT_COUNT_WIDTH)) dropCounter (
        .clock     (clock),
        .clear     (reset),
        .increment (dropEvent),
        .count     (framesDropped)
    );

    assign startRequest_tick = (state == S_Issue);
    assign active            = (state != S_Idle);
    assign debugState        = state;

endmodule

// File: tb/tb_render_frame_scheduler.sv
// Bench for render_frame_scheduler: directed table, hand sequences and a random run vs a frame-level model.
module tb_render_frame_scheduler;
    import render_sched_pkg::*;

    localparam int MIN_GAP = 16;
    localparam int WD      = 50;
`ifdef RENDER_SCHED_WATCHDOG_EN
    localparam bit WD_EN = 1'b1;
`else
    localparam bit WD_EN = 1'b0;
`endif

    logic         clock, reset, hostStart_tick, autoMode, vblank_tick, flowBusy, flowDone_tick;
    logic         startRequest_tick, flowAbort_tick, pending, active;
    logic [31:0]  framesIssued, lastLatency;
    logic [15:0]  framesDropped, timeoutCount;
    sched_state_t debugState;

    render_frame_scheduler #(.MIN_GAP_CYCLES(MIN_GAP), .WATCHDOG_CYCLES(32'(WD))) dut (
        .clock             (clock),
        .reset             (reset),
        .hostStart_tick    (hostStart_tick),
        .autoMode          (autoMode),
        .vblank_tick       (vblank_tick),
        .flowBusy          (flowBusy),
        .flowDone_tick     (flowDone_tick),
        .startRequest_tick (startRequest_tick),
        .flowAbort_tick    (flowAbort_tick),
        .pending           (pending),
        .active            (active),
        .framesIssued      (framesIssued),
        .framesDropped     (framesDropped),
        .timeoutCount      (timeoutCount),
        .lastLatency       (lastLatency),
        .debugState        (debugState)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    int tcyc = 0;
    int curCyc = 0;
    int starts = 0;

    // Frame-level model: 0 idle, 1 start pulse, 2 frame in flight, 3 gap.
    int          mPhase;
    int          mGapLeft;
    longint      mCyc = 0;
    longint      mT0;
    logic        mPending;
    logic [31:0] mIssued, mLat;
    logic [15:0] mDropped, mTimeouts;

    task automatic model_reset();
        mPhase = 0; mGapLeft = 0; mT0 = 0; mPending = 1'b0;
        mIssued = '0; mLat = '0; mDropped = '0; mTimeouts = '0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, curCyc, act, exp);
        end
    endtask

    task automatic run_cycle(input logic rs, input logic h, input logic a, input logic v,
                             input logic b, input logic d);
        logic [99:0] act, exp;
        logic        mStart, mAbort, evt, cons;
        @(negedge clock);
        reset = rs; hostStart_tick = h; autoMode = a; vblank_tick = v; flowBusy = b; flowDone_tick = d;
        #1;
        curCyc = tcyc;
        mStart = (mPhase == 1);
        mAbort = WD_EN && (mPhase == 2) && ((mCyc - mT0) == longint'(WD + 1)) && !d;
        exp = {mStart, mAbort, mPending, (mPhase != 0), mIssued, mDropped, mTimeouts, mLat};
        act = {startRequest_tick, flowAbort_tick, pending, active, framesIssued,
               framesDropped, timeoutCount, lastLatency};
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL model cyc=%0d actual=%h required=%h", curCyc, act, exp);
        end
        if (startRequest_tick === 1'b1) starts++;
        tcyc++;
        if (rs) begin
            model_reset();
        end else begin
            evt  = h | (a & v);
            cons = (mPhase == 0) && mPending;
            if (evt && mPending && !cons && (mDropped != 16'hFFFF)) mDropped++;
            mPending = evt || (mPending && !cons);
            case (mPhase)
                0: if (cons) mPhase = 1;
                1: begin mPhase = 2; mT0 = mCyc; mIssued++; end
                2: begin
                    if (d) begin
                        mLat = 32'(mCyc - mT0);
                        if (MIN_GAP > 0) begin mPhase = 3; mGapLeft = MIN_GAP; end
                        else mPhase = 0;
                    end else if (mAbort) begin
                        if (mTimeouts != 16'hFFFF) mTimeouts++;
                        mPhase = 3;
                        mGapLeft = (MIN_GAP > 0) ? MIN_GAP : 1;
                    end
                end
                default: begin
                    mGapLeft--;
                    if (mGapLeft == 0) mPhase = 0;
                end
            endcase
        end
        mCyc++;
    endtask

    task automatic do_reset();
        run_cycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tcyc = 0;
        starts = 0;
    endtask

    typedef struct {
        int          cyc;
        logic        h, a, v, b, d;
        logic        eStart, ePending, eActive;
        logic [31:0] eIssued;
        logic [15:0] eDropped;
        logic [31:0] eLat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic h, a, v, b, d, rs, sel;
        int   r, startsMark;

        vecs[0] = '{10,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 16'd0, 32'd0};
        vecs[1] = '{11,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 16'd0, 32'd0};
        vecs[2] = '{12,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'd0, 16'd0, 32'd0};
        vecs[3] = '{13,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1, 16'd0, 32'd0};
        vecs[4] = '{112, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'd1, 16'd0, 32'd0};
        vecs[5] = '{113, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1, 16'd0, 32'd100};
        vecs[6] = '{128, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1, 16'd0, 32'd100};
        vecs[7] = '{129, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd1, 16'd0, 32'd100};

        // Clock/reset block
        reset = 1'b1; hostStart_tick = 1'b0; autoMode = 1'b0; vblank_tick = 1'b0;
        flowBusy = 1'b0; flowDone_tick = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        run_cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("rst_start",   32'(startRequest_tick), 32'd0);
        chk("rst_abort",   32'(flowAbort_tick),    32'd0);
        chk("rst_pending", 32'(pending),           32'd0);
        chk("rst_active",  32'(active),            32'd0);
        chk("rst_issued",  framesIssued,           32'd0);
        chk("rst_dropped", 32'(framesDropped),     32'd0);
        chk("rst_timeout", 32'(timeoutCount),      32'd0);
        chk("rst_latency", lastLatency,            32'd0);
        chk("rst_state",   32'(debugState),        32'(S_Idle));

        // Single host request, table driven
        do_reset();
        r = 0; b = 1'b0;
        for (int c = 0; c <= 130; c++) begin
            h = 1'b0; a = 1'b0; v = 1'b0; d = 1'b0;
            if (r < 8 && vecs[r].cyc == c) begin
                h = vecs[r].h; a = vecs[r].a; v = vecs[r].v; b = vecs[r].b; d = vecs[r].d;
            end
            run_cycle(1'b0, h, a, v, b, d);
            if (r < 8 && vecs[r].cyc == c) begin
                chk("tbl_start",   32'(startRequest_tick), 32'(vecs[r].eStart));
                chk("tbl_pending", 32'(pending),           32'(vecs[r].ePending));
                chk("tbl_active",  32'(active),            32'(vecs[r].eActive));
                chk("tbl_issued",  framesIssued,           vecs[r].eIssued);
                chk("tbl_dropped", 32'(framesDropped),     32'(vecs[r].eDropped));
                chk("tbl_latency", lastLatency,            vecs[r].eLat);
                r++;
            end
        end

        // Auto mode: host and vblank together are one event
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            run_cycle(1'b0, c == 5, 1'b1, c == 5, 1'b0, 1'b0);
            if (c == 6) chk("auto_pending", 32'(pending), 32'd1);
            if (c == 7) chk("auto_start", 32'(startRequest_tick), 32'd1);
        end
        chk("auto_starts",  32'(starts),        32'd1);
        chk("auto_dropped", 32'(framesDropped), 32'd0);

        // Overflow: three requests during one frame, second start at done+18
        do_reset();
        for (int c = 0; c <= 70; c++) begin
            h = (c == 0) || (c == 20) || (c == 25) || (c == 30);
            run_cycle(1'b0, h, 1'b0, 1'b0, (c >= 3) && (c <= 50), c == 50);
            if (c == 40) begin
                chk("ovf_pending", 32'(pending),       32'd1);
                chk("ovf_dropped", 32'(framesDropped), 32'd2);
            end
            if (c == 67) chk("ovf_start_early", 32'(startRequest_tick), 32'd0);
            if (c == 68) chk("ovf_start_gap",   32'(startRequest_tick), 32'd1);
        end
        chk("ovf_starts", 32'(starts), 32'd2);

        // Watchdog window: a normal frame then one that never completes
        do_reset();
        for (int c = 0; c <= 100; c++) begin
            b = ((c >= 3) && (c <= 12)) || (c >= 33);
            run_cycle(1'b0, (c == 0) || (c == 30), 1'b0, 1'b0, b, c == 12);
            if (c == 82) chk("wd_abort_early", 32'(flowAbort_tick), 32'd0);
            if (c == 83) chk("wd_abort",       32'(flowAbort_tick), 32'(WD_EN));
            if (c == 84) begin
                chk("wd_abort_width", 32'(flowAbort_tick), 32'd0);
                chk("wd_count",       32'(timeoutCount),   32'(WD_EN));
                chk("wd_latency",     lastLatency,         32'd10);
            end
        end

        // Reset mid-frame with a pending request
        do_reset();
        startsMark = 0;
        for (int c = 0; c <= 85; c++) begin
            rs = (c == 42);
            h  = (c == 0) || (c == 10) || (c == 81);
            run_cycle(rs, h, 1'b0, 1'b0, (c >= 3) && (c < 42), 1'b0);
            if (c == 43) begin
                chk("mid_start",   32'(startRequest_tick), 32'd0);
                chk("mid_abort",   32'(flowAbort_tick),    32'd0);
                chk("mid_pending", 32'(pending),           32'd0);
                chk("mid_active",  32'(active),            32'd0);
                chk("mid_issued",  framesIssued,           32'd0);
                chk("mid_latency", lastLatency,            32'd0);
                startsMark = starts;
            end
            if (c == 82) chk("mid_quiet", 32'(starts - startsMark), 32'd0);
            if (c == 83) chk("mid_fresh_start", 32'(startRequest_tick), 32'd1);
        end

        // Randomized traffic against the model
        do_reset();
        a = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) a = ~a;
            run_cycle($urandom_range(0, 999) == 0, $urandom_range(0, 19) == 0, a,
                      $urandom_range(0, 15) == 0, $urandom_range(0, 1) == 1,
                      $urandom_range(0, 24) == 0);
        end

        // Saturation of the drop counter
        do_reset();
        for (int i = 0; i < 70000; i++) begin
            sel = 1'($urandom_range(0, 1));
            run_cycle(1'b0, sel, 1'b1, ~sel, 1'b0, 1'b0);
        end
        chk("sat_dropped", 32'(framesDropped), 32'h0000FFFF);
        chk("sat_pending", 32'(pending), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
